// File: rtl/robot_cmd_sequencer.sv
// Record/replay sequencer for robot motion commands: stores {cmd,dur} entries, then replays each one for (dur+1) ticks.
// Define ROBOT_SEQ_LOOP_EN to let loop_i restart replay from entry 0 instead of finishing in DONE.

module robot_cmd_sequencer #(
    parameter int DEPTH    = 256,
    parameter int CMD_W    = 2,
    parameter int DUR_W    = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      save_i,
    input  logic                      exec_i,
    input  logic                      clear_i,
    input  logic [CMD_W-1:0]          cmd_i,
    input  logic [DUR_W-1:0]          dur_i,
    input  logic                      loop_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      full_o,
    output logic                      err_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [$clog2(DEPTH)-1:0]  idx_o,
    output logic                      act_valid_o,
    output logic [CMD_W-1:0]          act_cmd_o,
    output logic [15:0]               torque_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = CMD_W + DUR_W;

    localparam logic [15:0] TORQUE_FWD   = 16'h0F0F;
    localparam logic [15:0] TORQUE_RIGHT = 16'h0F0C;
    localparam logic [15:0] TORQUE_LEFT  = 16'h0C0F;
    localparam logic [15:0] TORQUE_BACK  = 16'hF0F0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_LOAD,
        S_RUN_HOLD,
        S_DONE,
        S_CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0] hold_q, hold_d;
    logic             err_q, err_d;

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    rd_data_q;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [EW-1:0]    mem_wdata;
    logic             mem_re;

    logic [CMD_W-1:0] rd_cmd;
    logic [DUR_W-1:0] rd_dur;
    logic             full;
    logic             last_cmd;
    logic             tick_wrap;
    logic             hold_end;
    logic             loop_restart;

    assign rd_cmd    = rd_data_q[EW-1:DUR_W];
    assign rd_dur    = rd_data_q[DUR_W-1:0];
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign last_cmd  = ({1'b0, idx_q} == (count_q - 1'b1));
    assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    assign hold_end  = tick_wrap && (hold_q == rd_dur);

`ifdef ROBOT_SEQ_LOOP_EN
    assign loop_restart = loop_i;
`else
    logic unused_loop;
    assign unused_loop  = loop_i;
    assign loop_restart = 1'b0;
`endif

    // NOTE: the program RAM has no reset; only the CLEAR walk erases it, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            clr_addr_q <= '0;
            tick_q     <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            clr_addr_q <= clr_addr_d;
            tick_q     <= tick_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        clr_addr_d = clr_addr_q;
        tick_d     = tick_q;
        hold_d     = hold_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        mem_re     = 1'b0;

        if (clear_i && (state_q != S_CLEAR)) begin
            state_d    = S_CLEAR;
            clr_addr_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (exec_i) begin
                        if (count_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = '0;
                            state_d = S_RUN_LOAD;
                        end
                    end else if (save_i) begin
                        state_d = S_IDLE;
                        if (!full) begin
                            mem_we    = 1'b1;
                            mem_waddr = count_q[AW-1:0];
                            mem_wdata = {cmd_i, dur_i};
                            count_d   = count_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_RUN_LOAD: begin
                    if (exec_i) begin
                        idx_d = '0;
                    end else begin
                        mem_re  = 1'b1;
                        tick_d  = '0;
                        hold_d  = '0;
                        state_d = S_RUN_HOLD;
                    end
                end

                S_RUN_HOLD: begin
                    if (exec_i) begin
                        idx_d   = '0;
                        state_d = S_RUN_LOAD;
                    end else if (hold_end) begin
                        tick_d = '0;
                        if (!last_cmd) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_RUN_LOAD;
                        end else if (loop_restart) begin
                            idx_d   = '0;
                            state_d = S_RUN_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (tick_wrap) begin
                        tick_d = '0;
                        hold_d = hold_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_addr_q;
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        clr_addr_d = '0;
                        count_d    = '0;
                        err_d      = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // Action outputs are forced to zero outside the hold so the display stage sees a clean idle.
    always_comb begin
        torque_o = 16'h0000;
        if (state_q == S_RUN_HOLD) begin
            case (rd_cmd[1:0])
                2'b00:   torque_o = TORQUE_FWD;
                2'b01:   torque_o = TORQUE_RIGHT;
                2'b10:   torque_o = TORQUE_LEFT;
                default: torque_o = TORQUE_BACK;
            endcase
        end
    end

    assign act_valid_o = (state_q == S_RUN_HOLD);
    assign act_cmd_o   = act_valid_o ? rd_cmd : '0;
    assign busy_o      = (state_q == S_RUN_LOAD) || (state_q == S_RUN_HOLD) || (state_q == S_CLEAR);
    assign done_o      = (state_q == S_DONE);
    assign full_o      = full;
    assign err_o       = err_q;
    assign count_o     = count_q;
    assign idx_o       = idx_q;

endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// Scoreboard bench for robot_cmd_sequencer: expected holds are queued by the stimulus and checked by a monitor.
// With ROBOT_SEQ_LOOP_EN defined the loop scenario expects continuous replay instead of DONE.

module tb_robot_cmd_sequencer;

    localparam int DEPTH    = 4;
    localparam int CMD_W    = 2;
    localparam int DUR_W    = 4;
    localparam int TICK_DIV = 4;

    localparam logic [1:0] C_FWD   = 2'd0;
    localparam logic [1:0] C_RIGHT = 2'd1;
    localparam logic [1:0] C_LEFT  = 2'd2;
    localparam logic [1:0] C_BACK  = 2'd3;

    logic             clk;
    logic             rst;
    logic             save_i;
    logic             exec_i;
    logic             clear_i;
    logic [CMD_W-1:0] cmd_i;
    logic [DUR_W-1:0] dur_i;
    logic             loop_i;
    logic             busy_o;
    logic             done_o;
    logic             full_o;
    logic             err_o;
    logic [2:0]       count_o;
    logic [1:0]       idx_o;
    logic             act_valid_o;
    logic [CMD_W-1:0] act_cmd_o;
    logic [15:0]      torque_o;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] torque;
        logic [1:0]  idx;
        int          len;
    } hold_t;

    hold_t exp_q[$];
    int    total;
    int    bad;
    bit    done_seen;

    robot_cmd_sequencer #(
        .DEPTH    (DEPTH),
        .CMD_W    (CMD_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .save_i      (save_i),
        .exec_i      (exec_i),
        .clear_i     (clear_i),
        .cmd_i       (cmd_i),
        .dur_i       (dur_i),
        .loop_i      (loop_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .full_o      (full_o),
        .err_o       (err_o),
        .count_o     (count_o),
        .idx_o       (idx_o),
        .act_valid_o (act_valid_o),
        .act_cmd_o   (act_cmd_o),
        .torque_o    (torque_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [15:0] t, input logic [1:0] i, input int l);
        hold_t h;
        h.cmd = c;
        h.torque = t;
        h.idx = i;
        h.len = l;
        exp_q.push_back(h);
    endtask

    task automatic save(input logic [1:0] c, input logic [3:0] d);
        cmd_i  = c;
        dur_i  = d;
        save_i = 1'b1;
        tick();
        save_i = 1'b0;
    endtask

    task automatic exec();
        exec_i = 1'b1;
        tick();
        exec_i = 1'b0;
    endtask

    task automatic wait_hold(input logic [1:0] i);
        int n = 0;
        while (!(act_valid_o && idx_o == i) && n < 400) begin
            tick();
            n++;
        end
        check("wait_hold", {31'd0, act_valid_o && idx_o == i}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 400) begin
            tick();
            n++;
        end
        check("wait_done", {31'd0, done_o}, 32'd1);
    endtask

    // Monitor: measures each act_valid_o pulse and compares it with the oldest queued expectation.
    initial begin
        hold_t cur;
        hold_t exp;
        bit    in_hold = 1'b0;
        cur.len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_hold = 1'b0;
            end else begin
                if (done_o) done_seen = 1'b1;
                if (act_valid_o) begin
                    if (!in_hold) begin
                        in_hold    = 1'b1;
                        cur.cmd    = act_cmd_o;
                        cur.torque = torque_o;
                        cur.idx    = idx_o;
                        cur.len    = 1;
                    end else begin
                        cur.len++;
                    end
                end else if (in_hold) begin
                    in_hold = 1'b0;
                    check("gap_torque", {16'd0, torque_o}, 32'd0);
                    check("gap_cmd", {30'd0, act_cmd_o}, 32'd0);
                    check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("hold_cmd", {30'd0, cur.cmd}, {30'd0, exp.cmd});
                        check("hold_torque", {16'd0, cur.torque}, {16'd0, exp.torque});
                        check("hold_idx", {30'd0, cur.idx}, {30'd0, exp.idx});
                        check("hold_len", cur.len, exp.len);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        done_seen = 1'b0;
        rst       = 1'b1;
        save_i    = 1'b0;
        exec_i    = 1'b0;
        clear_i   = 1'b0;
        cmd_i     = '0;
        dur_i     = '0;
        loop_i    = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_flags", {27'd0, busy_o, done_o, full_o, err_o, act_valid_o}, 32'd0);
        check("rst_count", {29'd0, count_o}, 32'd0);
        check("rst_idx", {30'd0, idx_o}, 32'd0);
        check("rst_torque", {16'd0, torque_o}, 32'd0);
        check("rst_cmd", {30'd0, act_cmd_o}, 32'd0);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;

        // Record three commands and replay them
        save(C_FWD, 4'd0);
        save(C_RIGHT, 4'd1);
        save(C_BACK, 4'd2);
        check("t1_count", {29'd0, count_o}, 32'd3);
        check("t1_flags", {28'd0, full_o, err_o, done_o, busy_o}, 32'd0);
        push(C_FWD, 16'h0F0F, 2'd0, 4);
        push(C_RIGHT, 16'h0F0C, 2'd1, 8);
        push(C_BACK, 16'hF0F0, 2'd2, 12);
        exec_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            exec_i = 1'b0;
        end while (!act_valid_o && n < 20);
        check("t1_latency", n, 2);
        while (!done_o && n < 200) begin
            tick();
            n++;
        end
        check("t1_run_cycles", n, 28);
        check("t1_done", {29'd0, done_o, busy_o, act_valid_o}, 32'b100);
        check("t1_torque_idle", {16'd0, torque_o}, 32'd0);

        // Fill to DEPTH, then overflow
        save(C_LEFT, 4'd5);
        check("t2_done_drop", {31'd0, done_o}, 32'd0);
        check("t2_count4", {29'd0, count_o}, 32'd4);
        check("t2_full_noerr", {30'd0, full_o, err_o}, 32'b10);
        save(C_FWD, 4'd7);
        check("t2_count_sat", {29'd0, count_o}, 32'd4);
        check("t2_full_err", {30'd0, full_o, err_o}, 32'b11);
        push(C_FWD, 16'h0F0F, 2'd0, 4);
        push(C_RIGHT, 16'h0F0C, 2'd1, 8);
        push(C_BACK, 16'hF0F0, 2'd2, 12);
        push(C_LEFT, 16'h0C0F, 2'd3, 24);
        exec();
        wait_done();
        check("t2_err_sticky", {31'd0, err_o}, 32'd1);

        // Clear in the middle of command 1
        push(C_FWD, 16'h0F0F, 2'd0, 4);
        push(C_RIGHT, 16'h0F0C, 2'd1, 4);
        exec();
        wait_hold(2'd1);
        tick(3);
        n = 0;
        clear_i = 1'b1;
        tick();
        check("t4_abort", {31'd0, act_valid_o}, 32'd0);
        if (busy_o) n++;
        tick();
        clear_i = 1'b0;
        if (busy_o) n++;
        repeat (8) begin
            tick();
            if (busy_o) n++;
        end
        check("t4_busy_cycles", n, 4);
        check("t4_count", {29'd0, count_o}, 32'd0);
        check("t4_flags", {28'd0, err_o, full_o, done_o, busy_o}, 32'd0);

        // Exec with an empty program
        exec();
        check("t3_done", {30'd0, done_o, busy_o}, 32'b10);
        tick(3);
        check("t3_done_hold", {30'd0, done_o, act_valid_o}, 32'b10);

        // Simultaneous save/exec, save while running, exec restart
        save(C_LEFT, 4'd0);
        check("t5_done_drop", {31'd0, done_o}, 32'd0);
        save(C_FWD, 4'd1);
        check("t5_count2", {29'd0, count_o}, 32'd2);
        push(C_LEFT, 16'h0C0F, 2'd0, 4);
        push(C_FWD, 16'h0F0F, 2'd1, 1);
        push(C_LEFT, 16'h0C0F, 2'd0, 4);
        push(C_FWD, 16'h0F0F, 2'd1, 8);
        cmd_i  = C_BACK;
        dur_i  = 4'd3;
        save_i = 1'b1;
        exec_i = 1'b1;
        tick();
        save_i = 1'b0;
        exec_i = 1'b0;
        check("t5_save_dropped", {29'd0, count_o}, 32'd2);
        wait_hold(2'd0);
        save(C_BACK, 4'd0);
        check("t5_save_in_run", {29'd0, count_o}, 32'd2);
        wait_hold(2'd1);
        exec();
        wait_done();
        check("t5_count_end", {29'd0, count_o}, 32'd2);

        // Continuous replay request
        loop_i = 1'b1;
        exec();
        done_seen = 1'b0;
`ifdef ROBOT_SEQ_LOOP_EN
        push(C_LEFT, 16'h0C0F, 2'd0, 4);
        push(C_FWD, 16'h0F0F, 2'd1, 8);
        push(C_LEFT, 16'h0C0F, 2'd0, 4);
        push(C_FWD, 16'h0F0F, 2'd1, 8);
        push(C_LEFT, 16'h0C0F, 2'd0, 1);
        wait_hold(2'd1);
        wait_hold(2'd0);
        wait_hold(2'd1);
        wait_hold(2'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick(6);
        check("t6_loop_no_done", {31'd0, done_seen}, 32'd0);
        check("t6_loop_cleared", {29'd0, count_o}, 32'd0);
`else
        push(C_LEFT, 16'h0C0F, 2'd0, 4);
        push(C_FWD, 16'h0F0F, 2'd1, 8);
        wait_done();
        tick(4);
        check("t6_single_pass", {30'd0, done_o, act_valid_o}, 32'b10);
`endif
        loop_i = 1'b0;

        tick(2);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
